// File: rtl/dmx_frame_buffer_if.sv
// Host/transmitter bus for dmx_frame_buffer. When DMX_FB_ERR_EN is defined,
// the bus also carries the sticky wr_err flag.
interface dmx_frame_buffer_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic                  commit;
  logic                  commit_pending;
  logic                  frame_start;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_data;
  logic                  swap_done;
`ifdef DMX_FB_ERR_EN
  logic                  wr_err;

  modport master (
    output wr_valid, wr_addr, wr_data, commit, frame_start, rd_addr,
    input  wr_ready, commit_pending, rd_data, swap_done, wr_err
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, commit, frame_start, rd_addr,
    output wr_ready, commit_pending, rd_data, swap_done, wr_err
  );
`else
  modport master (
    output wr_valid, wr_addr, wr_data, commit, frame_start, rd_addr,
    input  wr_ready, commit_pending, rd_data, swap_done
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, commit, frame_start, rd_addr,
    output wr_ready, commit_pending, rd_data, swap_done
  );
`endif
endinterface

// File: rtl/dmx_frame_buffer.sv
// Double-buffered DMX channel store: host fills the shadow bank, swaps at frame_start,
// then copies live back into shadow. Optional sticky wr_err via DMX_FB_ERR_EN.
module dmx_frame_buffer #(
  parameter int CHANNEL_COUNT = 8,
  parameter int ADDR_WIDTH    = 5
) (
  input logic               clock,
  input logic               reset,
  dmx_frame_buffer_if.slave bus
);
  localparam int IW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHANNEL_COUNT - 1);

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  state_t          state, state_d;
  logic [7:0]      bank0 [CHANNEL_COUNT];
  logic [7:0]      bank1 [CHANNEL_COUNT];
  logic            bank_sel;
  logic [IW-1:0]   copy_idx;
  logic [7:0]      rd_data_q;
  logic            swap_done_q;

  logic [IW-1:0]   wr_idx, rd_idx;
  logic            wr_in_range, rd_in_range, wr_fire;
  logic            commit_take, do_swap, copy_last;

  assign wr_idx      = bus.wr_addr[IW-1:0];
  assign rd_idx      = bus.rd_addr[IW-1:0];
  assign wr_in_range = int'({1'b0, bus.wr_addr}) < CHANNEL_COUNT;
  assign rd_in_range = int'({1'b0, bus.rd_addr}) < CHANNEL_COUNT;
  assign wr_fire     = bus.wr_valid & (state == IDLE);
  assign commit_take = bus.commit & (state == IDLE);
  assign do_swap     = bus.frame_start & (state == PENDING);
  assign copy_last   = (state == COPY) && (copy_idx == LAST);

  assign bus.wr_ready       = (state == IDLE);
  assign bus.commit_pending = (state == PENDING);
  assign bus.rd_data        = rd_data_q;
  assign bus.swap_done      = swap_done_q;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.commit)      state_d = PENDING;
      PENDING: if (bus.frame_start) state_d = COPY;
      COPY:    if (copy_last)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bank_sel    <= 1'b0;
      copy_idx    <= '0;
      swap_done_q <= 1'b0;
    end else begin
      state       <= state_d;
      swap_done_q <= do_swap;
      if (do_swap) begin
        bank_sel <= ~bank_sel;
        copy_idx <= '0;
      end else if (state == COPY) begin
        copy_idx <= copy_last ? '0 : copy_idx + 1'b1;
      end
    end
  end

  // bank_sel=0 means bank0 is live; the other bank is the host-facing shadow.
  // Writes only happen in IDLE and copy-back only in COPY, so they never collide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        bank0[i] <= 8'h00;
        bank1[i] <= 8'h00;
      end
      rd_data_q <= 8'h00;
    end else begin
      if (wr_fire && wr_in_range) begin
        if (bank_sel) bank0[wr_idx] <= bus.wr_data;
        else          bank1[wr_idx] <= bus.wr_data;
      end
      if (state == COPY) begin
        if (bank_sel) bank0[copy_idx] <= bank1[copy_idx];
        else          bank1[copy_idx] <= bank0[copy_idx];
      end
      if (!rd_in_range)  rd_data_q <= 8'h00;
      else if (bank_sel) rd_data_q <= bank1[rd_idx];
      else               rd_data_q <= bank0[rd_idx];
    end
  end

`ifdef DMX_FB_ERR_EN
  logic wr_err_q;
  assign bus.wr_err = wr_err_q;

  // Set has priority over the clear from a commit in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        wr_err_q <= 1'b0;
    else if (wr_fire && !wr_in_range) wr_err_q <= 1'b1;
    else if (commit_take)             wr_err_q <= 1'b0;
  end
`else
  logic unused_ok;
  assign unused_ok = commit_take;
`endif

endmodule

// File: tb/tb_dmx_frame_buffer.sv
// Self-checking bench for dmx_frame_buffer: read expectations queued at drive time,
// popped when rd_data is due; table-driven full-frame pass plus hand sequences.
module tb_dmx_frame_buffer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmx_frame_buffer_if #(.ADDR_WIDTH(5)) bus ();
  dmx_frame_buffer #(.CHANNEL_COUNT(8), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic rd_pop(input string nm);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({nm, " (empty scoreboard)"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(nm, {24'h0, bus.rd_data}, {24'h0, e});
    end
  endtask

  // Inputs change at negedge; outputs are compared at the following negedge.
  task automatic rd(input logic [4:0] a, input logic [7:0] e, input string nm);
    bus.rd_addr = a;
    exp_q.push_back(e);
    @(negedge clock);
    rd_pop(nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic with_commit);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.commit   = with_commit;
    @(negedge clock);
    bus.wr_valid = 1'b0;
    bus.commit   = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    @(negedge clock);
    bus.commit = 1'b0;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    @(negedge clock);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, output int n);
    n = 0;
    while (!bus.wr_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({nm, " wr_ready"}, {31'h0, bus.wr_ready}, 32'd1);
  endtask

  task automatic sweep_zero(input string nm);
    for (int i = 0; i < 8; i++) rd(5'(i), 8'h00, nm);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{addr: 5'(i), data: 8'(8'h30 + 8'(i * 17)), exp: 8'(8'h30 + 8'(i * 17))};
    tbl[8] = '{addr: 5'd8,  data: 8'hEE, exp: 8'h00};
    tbl[9] = '{addr: 5'd30, data: 8'hDD, exp: 8'h00};

    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.commit = 0;
    bus.frame_start = 0; bus.rd_addr = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("reset swap_done", {31'h0, bus.swap_done}, 32'd0);
    check("reset commit_pending", {31'h0, bus.commit_pending}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: reset state
    sweep_zero("t1 rd after reset");
    check("t1 wr_ready", {31'h0, bus.wr_ready}, 32'd1);
    check("t1 commit_pending", {31'h0, bus.commit_pending}, 32'd0);

    // 2: single write, commit, swap, copy timing
    wr(5'd3, 8'hA5, 1'b0);
    pulse_commit();
    check("t2 commit_pending", {31'h0, bus.commit_pending}, 32'd1);
    check("t2 wr_ready low", {31'h0, bus.wr_ready}, 32'd0);
    wr(5'd3, 8'h99, 1'b0);  // blocked while pending
    rd(5'd3, 8'h00, "t2 rd3 before swap");
    pulse_frame();
    check("t2 swap_done", {31'h0, bus.swap_done}, 32'd1);
    check("t2 commit_pending clr", {31'h0, bus.commit_pending}, 32'd0);
    @(negedge clock);
    check("t2 swap_done one cycle", {31'h0, bus.swap_done}, 32'd0);
    n = 1;
    while (!bus.wr_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("t2 copy cycles", 32'(n), 32'd8);
    rd(5'd3, 8'hA5, "t2 rd3 after swap");
    rd(5'd11, 8'h00, "t2 rd out of range");

    // 3: partial update relies on copy-back; read during swap sees old bank
    wr(5'd4, 8'h11, 1'b0);
    pulse_commit();
    bus.rd_addr = 5'd4;
    exp_q.push_back(8'h00);
    pulse_frame();
    rd_pop("t3 rd4 same-cycle swap");
    wait_idle("t3", n);
    rd(5'd3, 8'hA5, "t3 rd3 copy-back");
    rd(5'd4, 8'h11, "t3 rd4");

    // 4: frame_start without commit; write+commit same cycle
    pulse_frame();
    check("t4 no swap_done", {31'h0, bus.swap_done}, 32'd0);
    check("t4 still idle", {31'h0, bus.wr_ready}, 32'd1);
    rd(5'd3, 8'hA5, "t4 rd3 unchanged");
    wr(5'd5, 8'h5A, 1'b1);
    check("t4 pending after wr+commit", {31'h0, bus.commit_pending}, 32'd1);
    rd(5'd5, 8'h00, "t4 rd5 before swap");
    pulse_frame();
    wait_idle("t4", n);
    rd(5'd5, 8'h5A, "t4 rd5 after swap");
    rd(5'd4, 8'h11, "t4 rd4 kept");

    // 5: reset during the third COPY cycle
    wr(5'd6, 8'h77, 1'b1);
    pulse_frame();
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check("t5 reset clears swap_done", {31'h0, bus.swap_done}, 32'd0);
    check("t5 reset to idle", {31'h0, bus.wr_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t5 wr_ready", {31'h0, bus.wr_ready}, 32'd1);
    check("t5 commit_pending", {31'h0, bus.commit_pending}, 32'd0);
    sweep_zero("t5 rd after reset");

    // 6: out-of-range writes are dropped (and flagged when enabled)
    wr(5'd9, 8'hFF, 1'b0);
`ifdef DMX_FB_ERR_EN
    check("t6 wr_err set", {31'h0, bus.wr_err}, 32'd1);
`endif
    wr(5'd2, 8'h22, 1'b0);
    wr(5'd11, 8'hFF, 1'b0);
    pulse_commit();
`ifdef DMX_FB_ERR_EN
    check("t6 wr_err cleared", {31'h0, bus.wr_err}, 32'd0);
`endif
    pulse_frame();
    wait_idle("t6", n);
    for (int i = 0; i < 8; i++)
      rd(5'(i), (i == 2) ? 8'h22 : 8'h00, "t6 rd");
`ifdef DMX_FB_ERR_EN
    // set wins over commit clear in the same cycle
    wr(5'd12, 8'h01, 1'b1);
    check("t6 wr_err set beats clear", {31'h0, bus.wr_err}, 32'd1);
    pulse_frame();
    wait_idle("t6b", n);
`endif

    // 7: full-frame table
    for (int i = 0; i < 10; i++) wr(tbl[i].addr, tbl[i].data, 1'b0);
    pulse_commit();
    pulse_frame();
    wait_idle("t7", n);
    for (int i = 0; i < 10; i++) rd(tbl[i].addr, tbl[i].exp, "t7 table rd");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
